// File: rtl/bin2dec_seq.sv
// -----------------------------------------------------------------------------
// bin2dec_seq
// -----------------------------------------------------------------------------
// Sequential binary-to-BCD converter using shift-and-add-3 ("double dabble"),
// retiring one operand bit per clock. Acts as the responder side of a
// start/ready handshake: the driver presents in_data, raises start, and waits
// for ready before sampling out_dec. The previously published result stays
// stable on out_dec while a new conversion is running.
//
// Parameters:
//   WIDTH   bit width of in_data
//   DIGITS  number of BCD digits in out_dec (10**DIGITS must exceed 2**WIDTH)
//
// Ports:
//   clock    in   system clock, rising-edge active
//   reset    in   synchronous, active-low reset
//   start    in   conversion request, accepted only in IDLE or DONE
//   in_data  in   [WIDTH-1:0] binary operand, captured on the accepting edge
//   ready    out  high while a valid result is held
//   busy     out  high while converting
//   out_dec  out  [4*DIGITS-1:0] BCD result, units digit in bits [3:0]
//   neg      out  result sign (only when BIN2DEC_SIGNED_EN is defined)
//
// Build option:
//   BIN2DEC_SIGNED_EN  treat in_data as two's complement; the magnitude is
//                      converted and the sign is reported on neg. Without
//                      the macro, in_data is unsigned and neg does not exist.
// -----------------------------------------------------------------------------

module bin2dec_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WIDTH-1:0]      in_data,
   output logic                  ready,
   output logic                  busy,
   output logic [4*DIGITS-1:0]   out_dec
`ifdef BIN2DEC_SIGNED_EN
   ,
   output logic                  neg
`endif
);

   localparam int          CNT_W = $clog2(WIDTH + 1);
   localparam int          BCD_W = 4 * DIGITS;
   localparam int unsigned NDIG  = DIGITS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q;
   state_t             state_d;

   logic [WIDTH-1:0]   sh_q;
   logic [BCD_W-1:0]   acc_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               ready_q;

   logic               accept;
   logic               last_step;
   logic [WIDTH-1:0]   operand;
   logic [BCD_W-1:0]   acc_adj;
   logic [BCD_W+WIDTH-1:0] shift_cat;
   logic [BCD_W-1:0]   acc_shift;
   logic [WIDTH-1:0]   sh_shift;

   // -------------------------------------------------------------------------
   // Handshake decode
   // -------------------------------------------------------------------------
   always_comb begin
      accept    = start && ((state_q == IDLE) || (state_q == DONE));
      last_step = (state_q == CONV) && (cnt_q == CNT_W'(1));
   end

   // -------------------------------------------------------------------------
   // Operand conditioning: the value loaded into the shift register.
   // In signed mode the magnitude is taken; the most negative input maps to
   // 2**(WIDTH-1), which still fits as an unsigned WIDTH-bit value.
   // -------------------------------------------------------------------------
   always_comb begin
`ifdef BIN2DEC_SIGNED_EN
      if (in_data[WIDTH-1]) begin
         operand = ~in_data + WIDTH'(1);
      end else begin
         operand = in_data;
      end
`else
      operand = in_data;
`endif
   end

   // -------------------------------------------------------------------------
   // One double-dabble step: every digit >= 5 is corrected by +3 in parallel,
   // then {acc, sh} shifts left by one so the MSB of sh enters acc[0].
   // -------------------------------------------------------------------------
   always_comb begin
      acc_adj = acc_q;
      for (int unsigned i = 0; i < NDIG; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) begin
            acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
         end
      end
      shift_cat = {acc_adj, sh_q} << 1;
      acc_shift = shift_cat[BCD_W+WIDTH-1:WIDTH];
      sh_shift  = shift_cat[WIDTH-1:0];
   end

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = CONV;
            end
         end
         CONV: begin
            // start is deliberately ignored here
            if (last_step) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (start) begin
               state_d = CONV;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (!reset) begin
         sh_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         out_dec <= '0;
      end else begin
         if (accept) begin
            sh_q  <= operand;
            acc_q <= '0;
            cnt_q <= CNT_W'(WIDTH);
         end else if (state_q == CONV) begin
            sh_q  <= sh_shift;
            acc_q <= acc_shift;
            cnt_q <= cnt_q - CNT_W'(1);
            // Publish only the completed value; the partial accumulator is
            // never visible on out_dec.
            if (last_step) begin
               out_dec <= acc_shift;
            end
         end
      end
   end

   // ready is registered from the state: it rises one edge after DONE is
   // entered (WIDTH+1 edges after acceptance) and falls one edge after a new
   // request is accepted out of DONE.
   always_ff @(posedge clock) begin
      if (!reset) begin
         ready_q <= 1'b0;
      end else begin
         ready_q <= (state_q == DONE);
      end
   end

`ifdef BIN2DEC_SIGNED_EN
   // Sign tracks the captured operand and changes only on acceptance.
   always_ff @(posedge clock) begin
      if (!reset) begin
         neg <= 1'b0;
      end else if (accept) begin
         neg <= in_data[WIDTH-1];
      end
   end
`endif

   // -------------------------------------------------------------------------
   // FSM: outputs
   // -------------------------------------------------------------------------
   always_comb begin
      busy  = (state_q == CONV);
      ready = ready_q;
   end

endmodule

// File: tb/tb_bin2dec_seq.sv
module tb_bin2dec_seq;

   logic        clock;
   logic        reset;
   logic        start;
   logic [7:0]  in_data;
   logic        ready;
   logic        busy;
   logic [11:0] out_dec;
`ifdef BIN2DEC_SIGNED_EN
   logic        neg;
`endif

   int total = 0;
   int bad   = 0;
   logic [11:0] last = '0;
   bit in_done = 0;

   bin2dec_seq #(.WIDTH(8), .DIGITS(3)) dut (
      .clock   (clock),
      .reset   (reset),
      .start   (start),
      .in_data (in_data),
      .ready   (ready),
      .busy    (busy),
      .out_dec (out_dec)
`ifdef BIN2DEC_SIGNED_EN
      ,
      .neg     (neg)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [7:0]  v;
      logic [11:0] d;
      logic        n;
   } vec_t;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Reference: decimal digits of the operand value by plain arithmetic.
   function automatic logic [11:0] ref_bcd(input logic [7:0] v);
      int n;
      n = int'(v);
`ifdef BIN2DEC_SIGNED_EN
      if (v[7]) n = 256 - n;
`endif
      return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
   endfunction

   function automatic logic ref_neg(input logic [7:0] v);
`ifdef BIN2DEC_SIGNED_EN
      return v[7];
`else
      return 1'b0;
`endif
   endfunction

   // One full conversion from IDLE or DONE with timing checks.
   // glitch_at > 0 presents start=1, in_data=1 at that conversion edge.
   task automatic run_conv(input string name, input logic [7:0] v,
                           input logic [11:0] exp_dec, input logic exp_neg,
                           input int glitch_at);
      in_data = v;
      start   = 1'b1;
      tick();                                  // edge 0 (accept)
      start   = 1'b0;
      in_data = 8'($urandom);
      chk({name, "_busy_e0"}, 32'(busy), 32'd1);
      chk({name, "_ready_e0"}, 32'(ready), 32'(in_done));
      for (int e = 1; e <= 8; e++) begin
         if (e == glitch_at) begin
            start   = 1'b1;
            in_data = 8'h01;
         end
         tick();
         start = 1'b0;
         if (e == 7) begin
            chk({name, "_busy_e7"}, 32'(busy), 32'd1);
            chk({name, "_ready_e7"}, 32'(ready), 32'd0);
            chk({name, "_hold_e7"}, 32'(out_dec), 32'(last));
         end
      end
      chk({name, "_busy_e8"}, 32'(busy), 32'd0);
      chk({name, "_ready_e8"}, 32'(ready), 32'd0);
      tick();                                  // edge 9
      chk({name, "_ready_e9"}, 32'(ready), 32'd1);
      chk({name, "_busy_e9"}, 32'(busy), 32'd0);
      chk({name, "_dec"}, 32'(out_dec), 32'(exp_dec));
`ifdef BIN2DEC_SIGNED_EN
      chk({name, "_neg"}, 32'(neg), 32'(exp_neg));
`else
      if (exp_neg) chk({name, "_neg_unexpected"}, 32'(exp_neg), 32'd0);
`endif
      last    = exp_dec;
      in_done = 1;
   endtask

   initial begin
      vec_t vecs[$];
      int   seen;
      logic [7:0] r;

`ifdef BIN2DEC_SIGNED_EN
      vecs.push_back('{8'h80, 12'h128, 1'b1});
      vecs.push_back('{8'hF6, 12'h010, 1'b1});
      vecs.push_back('{8'h7F, 12'h127, 1'b0});
      vecs.push_back('{8'h00, 12'h000, 1'b0});
      vecs.push_back('{8'hFF, 12'h001, 1'b1});
      vecs.push_back('{8'h63, 12'h099, 1'b0});
`else
      vecs.push_back('{8'hFF, 12'h255, 1'b0});
      vecs.push_back('{8'h00, 12'h000, 1'b0});
      vecs.push_back('{8'h64, 12'h100, 1'b0});
      vecs.push_back('{8'h0A, 12'h010, 1'b0});
      vecs.push_back('{8'h01, 12'h001, 1'b0});
      vecs.push_back('{8'h63, 12'h099, 1'b0});
      vecs.push_back('{8'hC8, 12'h200, 1'b0});
      vecs.push_back('{8'h80, 12'h128, 1'b0});
`endif

      // Reset state
      reset   = 1'b0;
      start   = 1'b1;
      in_data = 8'h55;
      tick();
      start   = 1'b0;
      tick();
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_dec", 32'(out_dec), 32'd0);
`ifdef BIN2DEC_SIGNED_EN
      chk("rst_neg", 32'(neg), 32'd0);
`endif
      reset = 1'b1;
      tick();

      // First conversion from IDLE, then ready holds with start low
      run_conv("c55", 8'h55, 12'h085, 1'b0, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("c55_hold_ready", 32'(ready), 32'd1);
         chk("c55_hold_dec", 32'(out_dec), 32'h085);
      end

      // Table vectors
      foreach (vecs[i]) begin
         run_conv($sformatf("vec%0d", i), vecs[i].v, vecs[i].d, vecs[i].n, 0);
      end

      // start and in_data change mid-conversion are ignored
      run_conv("glitch", 8'h37, 12'h055, 1'b0, 4);

      // Reset at edge 5 of a conversion discards the partial result
      in_data = 8'hC8;
      start   = 1'b1;
      tick();                                  // edge 0
      start   = 1'b0;
      for (int e = 1; e <= 4; e++) tick();
      reset = 1'b0;
      tick();                                  // edge 5
      reset = 1'b1;
      chk("midrst_ready", 32'(ready), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_dec", 32'(out_dec), 32'd0);
`ifdef BIN2DEC_SIGNED_EN
      chk("midrst_neg", 32'(neg), 32'd0);
`endif
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (ready || busy) seen++;
      end
      chk("midrst_no_activity", 32'(seen), 32'd0);
      last    = '0;
      in_done = 0;

      // start held high: back-to-back conversions
      in_data = 8'h64;
      start   = 1'b1;
      tick();                                  // edge 0
      for (int e = 1; e <= 8; e++) tick();
      chk("b2b_dec1", 32'(out_dec), 32'h100);
      chk("b2b_ready_e8", 32'(ready), 32'd0);
      in_data = 8'h0A;
      tick();                                  // edge 9: accepted from DONE
      chk("b2b_ready_e9", 32'(ready), 32'd1);
      chk("b2b_busy_e9", 32'(busy), 32'd1);
      chk("b2b_dec_e9", 32'(out_dec), 32'h100);
      tick();                                  // edge 10
      chk("b2b_ready_e10", 32'(ready), 32'd0);
      for (int e = 11; e <= 17; e++) tick();
      chk("b2b_dec2", 32'(out_dec), 32'h010);
      tick();                                  // edge 18
      chk("b2b_ready_e18", 32'(ready), 32'd1);
      start = 1'b0;
      for (int e = 19; e <= 27; e++) tick();
      chk("b2b_ready_e27", 32'(ready), 32'd1);
      chk("b2b_dec3", 32'(out_dec), 32'h010);
      last    = 12'h010;
      in_done = 1;

      // Randomized operands against the arithmetic model
      for (int i = 0; i < 24; i++) begin
         r = 8'($urandom);
         run_conv($sformatf("rnd%0d", i), r, ref_bcd(r), ref_neg(r), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
